// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit of the rv32imc pipeline.
package mem_stage_lsu_pkg;

    localparam logic [1:0] DEST_ALU  = 2'b00;
    localparam logic [1:0] DEST_LOAD = 2'b01;
    localparam logic [1:0] DEST_LINK = 2'b10;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } MemStateType;

    typedef struct packed {
        logic       memEn;
        logic       isStore;
        logic       isUnsigned;
        logic [1:0] size;
    } MemOpType;

    typedef struct packed {
        logic [4:0]  rdAddr;
        logic        rdWriteEn;
        logic [1:0]  destSelect;
        logic [31:0] pc;
        logic [31:0] aluResult;
        logic [31:0] storeData;
        MemOpType    memOp;
    } EXMEMLsuType;

    // Reserved select 11 falls through to the ALU result.
    function automatic logic [31:0] writeback_value(input logic [1:0] sel,
                                                    input logic [31:0] pc,
                                                    input logic [31:0] alu);
        return (sel == DEST_LINK) ? pc + 32'd4 : alu;
    endfunction

    // Size 11 is treated like a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        if (size == MEM_BYTE) return 1'b0;
        if (size == MEM_HALF) return addr_lo[0];
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering: store byte enables / replicated write data, and load lane extract + extend.
module load_store_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {addr_lo, 3'b000};

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = shifted;
        case (size)
            MEM_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = is_unsigned ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            end
            MEM_HALF: begin
                be        = 4'b0011 << addr_lo;
                wdata     = {2{store_data[15:0]}};
                load_data = is_unsigned ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: runs loads/stores on a req/gnt/rvalid port and registers the writeback bundle.
// Optional watchdog with busError output when LOOPYV_MEM_TIMEOUT_EN is defined.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        inValid,
    output logic        inReady,
    input  logic [4:0]  inRdAddr,
    input  logic        inRdWriteEn,
    input  logic [1:0]  inDestSelect,
    input  logic [31:0] inPc,
    input  logic [31:0] inAluResult,
    input  logic [31:0] inStoreData,
    input  logic [3:0]  inMemOp,
    input  logic [1:0]  inMemSize,
    output logic        dmemReq,
    output logic        dmemWe,
    output logic [31:0] dmemAddr,
    output logic [31:0] dmemWdata,
    output logic [3:0]  dmemBe,
    input  logic        dmemGnt,
    input  logic        dmemRvalid,
    input  logic [31:0] dmemRdata,
    output logic        outValid,
    output logic [4:0]  outRdAddr,
    output logic        outRdWriteEn,
    output logic [1:0]  outDestSelect,
    output logic [31:0] outPc,
    output logic [31:0] outRdWriteData,
`ifdef LOOPYV_MEM_TIMEOUT_EN
    output logic        busError,
`endif
    output logic        misaligned
);

    MemStateType state_q, state_d;
    EXMEMLsuType entry_q, entry_d, in_entry;
    logic        out_valid_q, out_valid_d;
    logic [4:0]  out_rd_addr_q, out_rd_addr_d;
    logic        out_rd_write_en_q, out_rd_write_en_d;
    logic [1:0]  out_dest_select_q, out_dest_select_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_rd_write_data_q, out_rd_write_data_d;
    logic        misaligned_q, misaligned_d;
    logic        finish, finish_we;
    logic [31:0] finish_data;
    logic        req_active;
    logic [3:0]  align_be;
    logic [31:0] align_wdata, align_load_data;
    logic        unused_mem_op_bit;

`ifdef LOOPYV_MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_error_q, bus_error_d;
`endif

    assign unused_mem_op_bit = inMemOp[0];

    assign in_entry = '{rdAddr:     inRdAddr,
                        rdWriteEn:  inRdWriteEn,
                        destSelect: inDestSelect,
                        pc:         inPc,
                        aluResult:  inAluResult,
                        storeData:  inStoreData,
                        memOp:      '{memEn: inMemOp[3], isStore: inMemOp[2],
                                      isUnsigned: inMemOp[1], size: inMemSize}};

    load_store_align u_align (
        .addr_lo     (entry_q.aluResult[1:0]),
        .size        (entry_q.memOp.size),
        .is_unsigned (entry_q.memOp.isUnsigned),
        .store_data  (entry_q.storeData),
        .rdata       (dmemRdata),
        .be          (align_be),
        .wdata       (align_wdata),
        .load_data   (align_load_data)
    );

    always_comb begin
        state_d             = state_q;
        entry_d             = entry_q;
        out_valid_d         = 1'b0;
        out_rd_addr_d       = out_rd_addr_q;
        out_rd_write_en_d   = out_rd_write_en_q;
        out_dest_select_d   = out_dest_select_q;
        out_pc_d            = out_pc_q;
        out_rd_write_data_d = out_rd_write_data_q;
        misaligned_d        = 1'b0;
        finish              = 1'b0;
        finish_we           = 1'b0;
        finish_data         = writeback_value(entry_q.destSelect, entry_q.pc, entry_q.aluResult);
`ifdef LOOPYV_MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
        bus_error_d = 1'b0;
`endif
        case (state_q)
            IDLE: if (inValid) begin
                entry_d             = in_entry;
                out_rd_addr_d       = inRdAddr;
                out_rd_write_en_d   = inRdWriteEn;
                out_dest_select_d   = inDestSelect;
                out_pc_d            = inPc;
                out_rd_write_data_d = writeback_value(inDestSelect, inPc, inAluResult);
                if (!in_entry.memOp.memEn) begin
                    out_valid_d = 1'b1;
                end else if (is_misaligned(inMemSize, inAluResult[1:0])) begin
                    out_valid_d       = 1'b1;
                    out_rd_write_en_d = 1'b0;
                    misaligned_d      = 1'b1;
                end else begin
                    state_d = REQ;
`ifdef LOOPYV_MEM_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            REQ: if (dmemGnt) begin
                if (entry_q.memOp.isStore) begin
                    finish = 1'b1;
                end else if (dmemRvalid) begin
                    finish      = 1'b1;
                    finish_we   = entry_q.rdWriteEn;
                    finish_data = align_load_data;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: if (dmemRvalid) begin
                finish      = 1'b1;
                finish_we   = entry_q.rdWriteEn;
                finish_data = align_load_data;
            end
            default: state_d = IDLE;
        endcase
`ifdef LOOPYV_MEM_TIMEOUT_EN
        // The access that hits the limit completes as a non-writing bundle flagged busError.
        if (!finish && (state_q == REQ || state_q == WAIT)) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                finish      = 1'b1;
                bus_error_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
        if (finish) begin
            state_d             = IDLE;
            out_valid_d         = 1'b1;
            out_rd_addr_d       = entry_q.rdAddr;
            out_rd_write_en_d   = finish_we;
            out_dest_select_d   = entry_q.destSelect;
            out_pc_d            = entry_q.pc;
            out_rd_write_data_d = finish_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and
    // clears every flop, so a reset mid-access simply drops the access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q             <= IDLE;
            entry_q             <= '0;
            out_valid_q         <= 1'b0;
            out_rd_addr_q       <= '0;
            out_rd_write_en_q   <= 1'b0;
            out_dest_select_q   <= '0;
            out_pc_q            <= '0;
            out_rd_write_data_q <= '0;
            misaligned_q        <= 1'b0;
`ifdef LOOPYV_MEM_TIMEOUT_EN
            cnt_q               <= '0;
            bus_error_q         <= 1'b0;
`endif
        end else begin
            state_q             <= state_d;
            entry_q             <= entry_d;
            out_valid_q         <= out_valid_d;
            out_rd_addr_q       <= out_rd_addr_d;
            out_rd_write_en_q   <= out_rd_write_en_d;
            out_dest_select_q   <= out_dest_select_d;
            out_pc_q            <= out_pc_d;
            out_rd_write_data_q <= out_rd_write_data_d;
            misaligned_q        <= misaligned_d;
`ifdef LOOPYV_MEM_TIMEOUT_EN
            cnt_q               <= cnt_d;
            bus_error_q         <= bus_error_d;
`endif
        end
    end

    // Request fields come straight from the held entry, so they stay stable until gnt.
    assign req_active = (state_q == REQ) && entry_q.memOp.memEn;
    assign inReady    = (state_q == IDLE);
    assign dmemReq    = req_active;
    assign dmemWe     = req_active && entry_q.memOp.isStore;
    assign dmemAddr   = req_active ? {entry_q.aluResult[31:2], 2'b00} : '0;
    assign dmemBe     = dmemWe ? align_be : '0;
    assign dmemWdata  = dmemWe ? align_wdata : '0;

    assign outValid       = out_valid_q;
    assign outRdAddr      = out_rd_addr_q;
    assign outRdWriteEn   = out_rd_write_en_q;
    assign outDestSelect  = out_dest_select_q;
    assign outPc          = out_pc_q;
    assign outRdWriteData = out_rd_write_data_q;
    assign misaligned     = misaligned_q;
`ifdef LOOPYV_MEM_TIMEOUT_EN
    assign busError       = bus_error_q;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu; define LOOPYV_MEM_TIMEOUT_EN to also exercise the watchdog.
module tb_mem_stage_lsu;
    import mem_stage_lsu_pkg::*;

    logic        clk, reset;
    logic        inValid, inReady, inRdWriteEn;
    logic [4:0]  inRdAddr;
    logic [1:0]  inDestSelect, inMemSize;
    logic [31:0] inPc, inAluResult, inStoreData;
    logic [3:0]  inMemOp;
    logic        dmemReq, dmemWe, dmemGnt, dmemRvalid;
    logic [31:0] dmemAddr, dmemWdata, dmemRdata;
    logic [3:0]  dmemBe;
    logic        outValid, outRdWriteEn, misaligned;
    logic [4:0]  outRdAddr;
    logic [1:0]  outDestSelect;
    logic [31:0] outPc, outRdWriteData;
    logic        bus_err_obs;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  sel;
        logic [31:0] pc;
        logic [31:0] data;
        logic        chk_data;
        logic        mis;
        logic        berr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

`ifdef LOOPYV_MEM_TIMEOUT_EN
    logic busError;
    assign bus_err_obs = busError;
`else
    assign bus_err_obs = 1'b0;
`endif

    mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .inValid        (inValid),
        .inReady        (inReady),
        .inRdAddr       (inRdAddr),
        .inRdWriteEn    (inRdWriteEn),
        .inDestSelect   (inDestSelect),
        .inPc           (inPc),
        .inAluResult    (inAluResult),
        .inStoreData    (inStoreData),
        .inMemOp        (inMemOp),
        .inMemSize      (inMemSize),
        .dmemReq        (dmemReq),
        .dmemWe         (dmemWe),
        .dmemAddr       (dmemAddr),
        .dmemWdata      (dmemWdata),
        .dmemBe         (dmemBe),
        .dmemGnt        (dmemGnt),
        .dmemRvalid     (dmemRvalid),
        .dmemRdata      (dmemRdata),
        .outValid       (outValid),
        .outRdAddr      (outRdAddr),
        .outRdWriteEn   (outRdWriteEn),
        .outDestSelect  (outDestSelect),
        .outPc          (outPc),
        .outRdWriteData (outRdWriteData),
`ifdef LOOPYV_MEM_TIMEOUT_EN
        .busError       (busError),
`endif
        .misaligned     (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every outValid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!reset && outValid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: outValid=1 pc=%h rd=%0d, required no result", outPc, outRdAddr);
            end else begin
                mon_e = exp_q.pop_front();
                if (outRdAddr !== mon_e.rd || outRdWriteEn !== mon_e.we || outDestSelect !== mon_e.sel ||
                    outPc !== mon_e.pc || misaligned !== mon_e.mis || bus_err_obs !== mon_e.berr ||
                    (mon_e.chk_data && outRdWriteData !== mon_e.data)) begin
                    errors++;
                    $display("FAIL out_bundle: got rd=%0d we=%b sel=%b pc=%h data=%h mis=%b berr=%b, required rd=%0d we=%b sel=%b pc=%h data=%h(chk=%b) mis=%b berr=%b",
                             outRdAddr, outRdWriteEn, outDestSelect, outPc, outRdWriteData, misaligned, bus_err_obs,
                             mon_e.rd, mon_e.we, mon_e.sel, mon_e.pc, mon_e.data, mon_e.chk_data, mon_e.mis, mon_e.berr);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        inValid = 1'b0; inRdAddr = '0; inRdWriteEn = 1'b0; inDestSelect = '0;
        inPc = '0; inAluResult = '0; inStoreData = '0; inMemOp = '0; inMemSize = '0;
        dmemGnt = 1'b0; dmemRvalid = 1'b0; dmemRdata = '0;
    endtask

    task automatic drive_entry(input logic [4:0] rd, input logic we, input logic [1:0] sel,
                               input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] sd,
                               input logic [3:0] op, input logic [1:0] size);
        inValid = 1'b1; inRdAddr = rd; inRdWriteEn = we; inDestSelect = sel;
        inPc = pc; inAluResult = alu; inStoreData = sd; inMemOp = op; inMemSize = size;
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic we, input logic [1:0] sel,
                            input logic [31:0] pc, input logic [31:0] data, input logic chk_data,
                            input logic mis, input logic berr);
        exp_t e;
        e = '{rd: rd, we: we, sel: sel, pc: pc, data: data, chk_data: chk_data, mis: mis, berr: berr};
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d results still pending after %0d cycles, required 0", name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if (inReady !== 1'b1) begin
            errors++; $display("FAIL reset_inReady: got %b, required 1", inReady);
        end
        checks++;
        if (outValid !== 1'b0 || dmemReq !== 1'b0 || misaligned !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: got outValid=%b dmemReq=%b misaligned=%b, required 0/0/0", outValid, dmemReq, misaligned);
        end
        checks++;
        if (outRdWriteData !== 32'h0 || dmemBe !== 4'h0 || dmemAddr !== 32'h0) begin
            errors++; $display("FAIL reset_data: got wdata=%h be=%h addr=%h, required 0", outRdWriteData, dmemBe, dmemAddr);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_alu();
        drive_entry(5'd5, 1'b1, DEST_ALU, 32'h10, 32'h0000_1234, 32'h0, 4'b0000, MEM_WORD);
        push_exp(5'd5, 1'b1, DEST_ALU, 32'h10, 32'h0000_1234, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        clear_inputs();
        checks++;
        if (outValid !== 1'b1 || outRdWriteData !== 32'h0000_1234) begin
            errors++; $display("FAIL alu_next_cycle: got outValid=%b data=%h, required 1 / 00001234", outValid, outRdWriteData);
        end
        wait_drain("alu", 4);
    endtask

    task automatic test_link();
        drive_entry(5'd1, 1'b1, DEST_LINK, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 4'b0000, MEM_WORD);
        push_exp(5'd1, 1'b1, DEST_LINK, 32'h0000_0100, 32'h0000_0104, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive_entry(5'd2, 1'b1, 2'b11, 32'h0000_0200, 32'h5555_AAAA, 32'h0, 4'b0000, MEM_WORD);
        push_exp(5'd2, 1'b1, 2'b11, 32'h0000_0200, 32'h5555_AAAA, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        clear_inputs();
        wait_drain("link", 4);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            drive_entry(5'(k + 10), 1'b1, DEST_ALU, 32'h300 + 32'(4 * k), 32'hA0 + 32'(k), 32'h0, 4'b0000, MEM_WORD);
            push_exp(5'(k + 10), 1'b1, DEST_ALU, 32'h300 + 32'(4 * k), 32'hA0 + 32'(k), 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (outValid !== 1'b1 || inReady !== 1'b1) begin
                errors++; $display("FAIL b2b_valid_%0d: got outValid=%b inReady=%b, required 1/1", k, outValid, inReady);
            end
        end
        clear_inputs();
        @(negedge clk);
        checks++;
        if (outValid !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: got outValid=%b, required 0", outValid);
        end
        wait_drain("b2b", 2);
    endtask

    task automatic test_load_byte();
        drive_entry(5'd7, 1'b1, DEST_LOAD, 32'h40, 32'h0000_1003, 32'h0, 4'b1000, MEM_BYTE);
        push_exp(5'd7, 1'b1, DEST_LOAD, 32'h40, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        clear_inputs();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (dmemReq !== 1'b1 || dmemWe !== 1'b0 || dmemAddr !== 32'h1000 || dmemBe !== 4'b0000 || inReady !== 1'b0) begin
                errors++;
                $display("FAIL load_req_%0d: got req=%b we=%b addr=%h be=%b inReady=%b, required 1/0/00001000/0000/0",
                         c, dmemReq, dmemWe, dmemAddr, dmemBe, inReady);
            end
            if (c == 2) dmemGnt = 1'b1;
            @(negedge clk);
        end
        dmemGnt = 1'b0;
        checks++;
        if (dmemReq !== 1'b0 || inReady !== 1'b0 || outValid !== 1'b0) begin
            errors++; $display("FAIL load_wait: got req=%b inReady=%b outValid=%b, required 0/0/0", dmemReq, inReady, outValid);
        end
        dmemRvalid = 1'b1;
        dmemRdata  = 32'h80FF_FFFF;
        @(negedge clk);
        dmemRvalid = 1'b0;
        dmemRdata  = '0;
        checks++;
        if (outValid !== 1'b1 || inReady !== 1'b1) begin
            errors++; $display("FAIL load_done: got outValid=%b inReady=%b, required 1/1", outValid, inReady);
        end
        wait_drain("load_byte", 4);
    endtask

    task automatic test_load_same_cycle();
        drive_entry(5'd8, 1'b1, DEST_LOAD, 32'h44, 32'h0000_1002, 32'h0, 4'b1010, MEM_HALF);
        push_exp(5'd8, 1'b1, DEST_LOAD, 32'h44, 32'h0000_8001, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        clear_inputs();
        dmemGnt    = 1'b1;
        dmemRvalid = 1'b1;
        dmemRdata  = 32'h8001_0000;
        @(negedge clk);
        clear_inputs();
        checks++;
        if (outValid !== 1'b1 || dmemReq !== 1'b0) begin
            errors++; $display("FAIL load_same_cycle: got outValid=%b dmemReq=%b, required 1/0", outValid, dmemReq);
        end
        wait_drain("load_half", 4);
    endtask

    task automatic test_store_half();
        drive_entry(5'd3, 1'b1, DEST_ALU, 32'h80, 32'h0000_2002, 32'h0000_ABCD, 4'b1100, MEM_HALF);
        push_exp(5'd3, 1'b0, DEST_ALU, 32'h80, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        clear_inputs();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (dmemReq !== 1'b1 || dmemWe !== 1'b1 || dmemAddr !== 32'h2000 || dmemBe !== 4'b1100 ||
                dmemWdata !== 32'hABCD_ABCD || inReady !== 1'b0) begin
                errors++;
                $display("FAIL store_req_%0d: got req=%b we=%b addr=%h be=%b wdata=%h inReady=%b, required 1/1/00002000/1100/abcdabcd/0",
                         c, dmemReq, dmemWe, dmemAddr, dmemBe, dmemWdata, inReady);
            end
            if (c == 3) dmemGnt = 1'b1;
            @(negedge clk);
        end
        dmemGnt = 1'b0;
        checks++;
        if (dmemReq !== 1'b0 || inReady !== 1'b1 || outValid !== 1'b1) begin
            errors++; $display("FAIL store_done: got req=%b inReady=%b outValid=%b, required 0/1/1", dmemReq, inReady, outValid);
        end
        wait_drain("store_half", 4);
    endtask

    task automatic test_misaligned();
        drive_entry(5'd9, 1'b1, DEST_LOAD, 32'h90, 32'h0000_3001, 32'h0, 4'b1000, MEM_WORD);
        push_exp(5'd9, 1'b0, DEST_LOAD, 32'h90, 32'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (dmemReq !== 1'b0 || misaligned !== 1'b1 || inReady !== 1'b1) begin
            errors++; $display("FAIL misaligned_word: got req=%b misaligned=%b inReady=%b, required 0/1/1", dmemReq, misaligned, inReady);
        end
        drive_entry(5'd6, 1'b1, DEST_ALU, 32'h94, 32'h0000_2001, 32'h1234, 4'b1100, MEM_HALF);
        push_exp(5'd6, 1'b0, DEST_ALU, 32'h94, 32'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        clear_inputs();
        checks++;
        if (dmemReq !== 1'b0 || misaligned !== 1'b1) begin
            errors++; $display("FAIL misaligned_half: got req=%b misaligned=%b, required 0/1", dmemReq, misaligned);
        end
        @(negedge clk);
        checks++;
        if (misaligned !== 1'b0 || dmemReq !== 1'b0) begin
            errors++; $display("FAIL misaligned_pulse: got misaligned=%b req=%b, required 0/0", misaligned, dmemReq);
        end
        wait_drain("misaligned", 2);
    endtask

    task automatic test_reset_mid_access();
        drive_entry(5'd11, 1'b1, DEST_LOAD, 32'hA0, 32'h0000_4000, 32'h0, 4'b1000, MEM_WORD);
        @(negedge clk);
        clear_inputs();
        dmemGnt = 1'b1;
        @(negedge clk);
        dmemGnt = 1'b0;
        checks++;
        if (dmemReq !== 1'b0 || inReady !== 1'b0) begin
            errors++; $display("FAIL rst_mid_wait: got req=%b inReady=%b, required 0/0", dmemReq, inReady);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (inReady !== 1'b1 || outValid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_idle: got inReady=%b outValid=%b, required 1/0", inReady, outValid);
        end
        dmemRvalid = 1'b1;
        dmemRdata  = 32'h1234_5678;
        @(negedge clk);
        clear_inputs();
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (outValid !== 1'b0 || inReady !== 1'b1 || dmemReq !== 1'b0) begin
                errors++; $display("FAIL rst_mid_ignore_%0d: got outValid=%b inReady=%b req=%b, required 0/1/0", c, outValid, inReady, dmemReq);
            end
            @(negedge clk);
        end
    endtask

`ifdef LOOPYV_MEM_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        drive_entry(5'd4, 1'b1, DEST_LOAD, 32'h200, 32'h0000_5000, 32'h0, 4'b1000, MEM_WORD);
        push_exp(5'd4, 1'b0, DEST_LOAD, 32'h200, 32'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        clear_inputs();
        n = 0;
        for (int c = 0; c < 10 && dmemReq === 1'b1; c++) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL timeout_req_cycles: got %0d, required 4", n);
        end
        checks++;
        if (busError !== 1'b1 || outValid !== 1'b1 || inReady !== 1'b1) begin
            errors++; $display("FAIL timeout_abort: got busError=%b outValid=%b inReady=%b, required 1/1/1", busError, outValid, inReady);
        end
        wait_drain("timeout", 2);
        checks++;
        if (busError !== 1'b0) begin
            errors++; $display("FAIL timeout_pulse: got busError=%b, required 0", busError);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_link();
        test_back_to_back();
        test_load_byte();
        test_load_same_cycle();
        test_store_half();
        test_misaligned();
        test_reset_mid_access();
`ifdef LOOPYV_MEM_TIMEOUT_EN
        test_timeout();
`endif
        wait_drain("final", 4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
